// File: rtl/move_capture_writer.sv
// Move capture for one player: synchronises and debounces the rock/paper/scissors buttons,
// locks a one-hot move word with a load strobe. Optional auto-lock via `RPS_TIMEOUT_EN.
module move_capture_writer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       round_active,
   input  logic       round_clear,
   input  logic [2:0] btn,
   output logic [4:0] data_out,
   output logic       load,
   output logic       locked
);

   localparam int unsigned MaxCycles =
      (DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ? DEBOUNCE_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned CntW = $clog2(MaxCycles) + 1;
   localparam logic [CntW-1:0] DebLast = CntW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

   typedef enum logic [1:0] {StIdle, StDebounce, StLocked, StRelease} state_e;

   state_e          state_q, state_d;
   logic [2:0]      s1_q, bs_q;
   logic [2:0]      cand_q, cand_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [4:0]      data_q, data_d;
   logic            load_q, load_d;
   logic            bs_onehot;

`ifdef RPS_TIMEOUT_EN
   localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
   logic [CntW-1:0] tcnt_q, tcnt_d;
`endif

   assign bs_onehot = (bs_q == 3'b001) || (bs_q == 3'b010) || (bs_q == 3'b100);

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      load_d  = 1'b0;
`ifdef RPS_TIMEOUT_EN
      tcnt_d  = '0;
`endif
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (round_clear) begin
               state_d = StRelease;
               data_d  = '0;
            end else if (round_active && bs_onehot) begin
               state_d = StDebounce;
               cand_d  = bs_q;
            end
`ifdef RPS_TIMEOUT_EN
            else if (round_active) begin
               if (tcnt_q == TmoLast) begin
                  state_d = StLocked;
                  data_d  = 5'b11001;
                  load_d  = 1'b1;
               end else if (tcnt_q != CntMax) begin
                  tcnt_d = tcnt_q + 1'b1;
               end else begin
                  tcnt_d = tcnt_q;
               end
            end
`endif
         end
         StDebounce: begin
            // Clear beats a lock that would land on the same edge.
            if (round_clear) begin
               state_d = StRelease;
               cnt_d   = '0;
               data_d  = '0;
            end else if (!round_active || (bs_q != cand_q)) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else if (cnt_q == DebLast) begin
               state_d = StLocked;
               data_d  = {1'b1, 1'b0, cand_q};
               load_d  = 1'b1;
               cnt_d   = '0;
            end else if (cnt_q != CntMax) begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StLocked: begin
            if (round_clear) begin
               state_d = StRelease;
               data_d  = '0;
            end
         end
         StRelease: begin
            // Wait for all buttons up so a held button cannot re-lock next round.
            if (bs_q == 3'b000) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         s1_q    <= 3'b000;
         bs_q    <= 3'b000;
         state_q <= StIdle;
         cand_q  <= 3'b000;
         cnt_q   <= '0;
         data_q  <= 5'b00000;
         load_q  <= 1'b0;
      end else begin
         s1_q    <= btn;
         bs_q    <= s1_q;
         state_q <= state_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         load_q  <= load_d;
      end
   end

`ifdef RPS_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!resetn) begin
         tcnt_q <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`endif

   assign data_out = data_q;
   assign load     = load_q;
   assign locked   = data_q[4];

endmodule

// File: tb/tb_move_capture_writer.sv
// Self-checking bench for move_capture_writer: directed scenarios plus randomized stimulus
// against a streak-counting reference model.
module tb_move_capture_writer;

   localparam int unsigned D = 4;
   localparam int unsigned T = 16;
`ifdef RPS_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       round_active = 1'b0;
   logic       round_clear = 1'b0;
   logic [2:0] btn = 3'b000;
   logic [4:0] data_out;
   logic       load;
   logic       locked;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   logic [2:0] m_s1, m_bs, m_move;
   logic [4:0] m_word;
   logic       m_load, m_release;
   int         m_streak, m_idle;

   move_capture_writer #(
      .DEBOUNCE_CYCLES(D),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .round_active(round_active),
      .round_clear (round_clear),
      .btn         (btn),
      .data_out    (data_out),
      .load        (load),
      .locked      (locked)
   );

   always #5 clk = ~clk;

   // A move locks once the same one-hot sample has been seen with the round open on
   // D+1 consecutive edges since arming; a held move is released only by round_clear,
   // after which all buttons must be seen up before arming again.
   task automatic model_edge();
      logic [2:0] nb;
      nb     = m_bs;
      m_load = 1'b0;
      if (!resetn) begin
         m_word = '0; m_release = 1'b0; m_streak = 0; m_idle = 0; m_move = '0;
         m_s1 = '0; m_bs = '0;
         return;
      end
      if (m_word[4]) begin
         m_idle = 0;
         if (round_clear) begin
            m_word = '0; m_release = 1'b1;
         end
      end else if (round_clear) begin
         m_release = 1'b1; m_streak = 0; m_idle = 0;
      end else if (m_release) begin
         m_idle = 0;
         if (nb == 3'b000) m_release = 1'b0;
      end else if (m_streak > 0) begin
         m_idle = 0;
         if (round_active && nb == m_move) begin
            m_streak++;
            if (m_streak == D + 1) begin
               m_word = {2'b10, m_move}; m_load = 1'b1; m_streak = 0;
            end
         end else begin
            m_streak = 0;
         end
      end else if (round_active && $countones(nb) == 1) begin
         m_move = nb; m_streak = 1; m_idle = 0;
      end else if (round_active && TimeoutEn) begin
         if (m_idle == T - 1) begin
            m_word = 5'b11001; m_load = 1'b1; m_idle = 0;
         end else begin
            m_idle++;
         end
      end else begin
         m_idle = 0;
      end
      m_bs = m_s1;
      m_s1 = btn;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      btn = 3'b000; round_active = 1'b0; round_clear = 1'b1;
      step();
      round_clear = 1'b0;
      repeat (4) step();
   endtask

   task automatic test_reset();
      resetn = 1'b0; btn = 3'b010; round_active = 1'b1;
      step(); step();
      n_vec++; if (data_out !== 5'b00000) begin n_err++;
         $display("FAIL reset_data: got %b want 00000", data_out); end
      n_vec++; if (load !== 1'b0) begin n_err++;
         $display("FAIL reset_load: got %b want 0", load); end
      n_vec++; if (locked !== 1'b0) begin n_err++;
         $display("FAIL reset_locked: got %b want 0", locked); end
      resetn = 1'b1;
   endtask

   task automatic test_lock();
      for (int i = 1; i <= 6; i++) begin
         step();
         n_vec++; if (load !== 1'b0 || data_out !== 5'b00000) begin n_err++;
            $display("FAIL lock_early edge %0d: load=%b data=%b want 0/00000", i, load, data_out);
         end
      end
      step();
      n_vec++; if (data_out !== 5'b10010) begin n_err++;
         $display("FAIL lock_data: got %b want 10010", data_out); end
      n_vec++; if (load !== 1'b1) begin n_err++;
         $display("FAIL lock_load: got %b want 1", load); end
      n_vec++; if (locked !== 1'b1) begin n_err++;
         $display("FAIL lock_locked: got %b want 1", locked); end
      btn = 3'b100; round_active = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++; if (load !== 1'b0 || data_out !== 5'b10010 || locked !== 1'b1) begin n_err++;
            $display("FAIL lock_hold %0d: load=%b data=%b locked=%b want 0/10010/1",
                     i, load, data_out, locked);
         end
      end
      round_clear = 1'b1;
      step();
      round_clear = 1'b0;
      n_vec++; if (data_out !== 5'b00000 || locked !== 1'b0) begin n_err++;
         $display("FAIL lock_clear: data=%b locked=%b want 00000/0", data_out, locked); end
      btn = 3'b010; round_active = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_vec++; if (data_out !== 5'b00000 || load !== 1'b0) begin n_err++;
            $display("FAIL release_hold %0d: data=%b load=%b want 00000/0", i, data_out, load);
         end
      end
      settle();
   endtask

   task automatic test_bounce();
      round_active = 1'b1; btn = 3'b001;
      repeat (3) step();
      btn = 3'b000;
      for (int i = 0; i < 10; i++) begin
         step();
         n_vec++; if (load !== 1'b0 || data_out !== 5'b00000) begin n_err++;
            $display("FAIL bounce %0d: load=%b data=%b want 0/00000", i, load, data_out);
         end
      end
      settle();
   endtask

   task automatic test_multi_release();
      round_active = 1'b1; btn = 3'b011;
      for (int i = 0; i < 20; i++) begin
         step();
         n_vec++; if (locked !== m_word[4] || data_out !== m_word) begin n_err++;
            $display("FAIL multi %0d: data=%b want %b", i, data_out, m_word);
         end
      end
      round_clear = 1'b1; btn = 3'b100;
      step();
      round_clear = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         n_vec++; if (data_out !== 5'b00000 || load !== 1'b0) begin n_err++;
            $display("FAIL held_after_clear %0d: data=%b load=%b want 00000/0", i, data_out, load);
         end
      end
      btn = 3'b000;
      repeat (3) step();
      btn = 3'b100;
      repeat (7) step();
      n_vec++; if (data_out !== 5'b10100 || load !== 1'b1) begin n_err++;
         $display("FAIL fresh_lock: data=%b load=%b want 10100/1", data_out, load); end
      settle();
   endtask

   task automatic test_clear_on_lock();
      round_active = 1'b1; btn = 3'b100;
      repeat (6) step();
      round_clear = 1'b1;
      step();
      round_clear = 1'b0;
      n_vec++; if (load !== 1'b0 || data_out !== 5'b00000) begin n_err++;
         $display("FAIL clear_on_lock: load=%b data=%b want 0/00000", load, data_out); end
      for (int i = 0; i < 8; i++) begin
         step();
         n_vec++; if (load !== 1'b0 || data_out !== 5'b00000) begin n_err++;
            $display("FAIL clear_release %0d: load=%b data=%b want 0/00000", i, load, data_out);
         end
      end
      settle();
   endtask

   task automatic test_timeout();
      round_active = 1'b1; btn = 3'b000;
`ifdef RPS_TIMEOUT_EN
      for (int i = 1; i < T; i++) begin
         step();
         n_vec++; if (load !== 1'b0 || data_out !== 5'b00000) begin n_err++;
            $display("FAIL timeout_early %0d: load=%b data=%b", i, load, data_out);
         end
      end
      step();
      n_vec++; if (data_out !== 5'b11001 || load !== 1'b1 || locked !== 1'b1) begin n_err++;
         $display("FAIL timeout_lock: data=%b load=%b want 11001/1", data_out, load); end
      step();
      n_vec++; if (load !== 1'b0) begin n_err++;
         $display("FAIL timeout_load_pulse: got %b want 0", load); end
`else
      for (int i = 0; i < 100; i++) begin
         step();
         n_vec++; if (data_out !== 5'b00000 || load !== 1'b0) begin n_err++;
            $display("FAIL no_timeout %0d: data=%b load=%b want 00000/0", i, data_out, load);
         end
      end
`endif
      settle();
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(7, 0) == 0) begin
            if ($urandom_range(1, 0) == 0) btn = 3'b001 << $urandom_range(2, 0);
            else btn = 3'($urandom);
         end
         round_active = ($urandom_range(15, 0) != 0);
         round_clear  = ($urandom_range(39, 0) == 0);
         resetn       = ($urandom_range(299, 0) != 0);
         step();
         n_vec++; if (data_out !== m_word || load !== m_load || locked !== m_word[4]) begin
            n_err++;
            $display("FAIL random %0d: data=%b load=%b locked=%b want %b/%b/%b",
                     i, data_out, load, locked, m_word, m_load, m_word[4]);
         end
      end
      resetn = 1'b1; round_clear = 1'b0;
   endtask

   initial begin
      m_s1 = '0; m_bs = '0; m_move = '0; m_word = '0;
      m_load = 1'b0; m_release = 1'b0; m_streak = 0; m_idle = 0;
      #2;
      test_reset();
      test_lock();
      test_bounce();
      test_multi_release();
      test_clear_on_lock();
      test_timeout();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
